grid_scan_reader: RTL and testbench

- Read-side engine for the Tetris grid memory.
- On a start pulse it walks the grid in raster order, top row first, left to right, reading one cell per access from the grid memory's second read port.
- It streams only the interior (playfield) cells to a downstream consumer, such as the display renderer or a row serializer, over a valid/ready handshake with backpressure.
- It is the consumer counterpart to the line clearer and piece placer, which write the grid on port A.

---
 rtl/grid_scan_reader.sv | 168 ++++++++++++++++
 tb/tb_grid_scan_reader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_scan_reader.sv
// Raster-order reader for the Tetris grid. It streams the interior cells over a valid/ready handshake.
// Optional macro GRID_SCAN_ROWFULL_EN adds a row_full flag on the last interior cell of each row.
module grid_scan_reader #(
    parameter int unsigned COLS   = 12,
    parameter int unsigned ROWS   = 20,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] cell_data,
    output logic [4:0]        cell_row,
    output logic [3:0]        cell_col,
    output logic              cell_last,
    output logic              cell_valid,
    input  logic              cell_ready
`ifdef GRID_SCAN_ROWFULL_EN
    ,
    output logic              row_full
`endif
);

    localparam int unsigned ROW_W = 5;
    localparam int unsigned COL_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CAPT,
        S_OUT,
        S_DONE
    } state_t;

    state_t            state, state_n;
    logic [ROW_W-1:0]  row, row_n;
    logic [COL_W-1:0]  col, col_n;
    logic              busy_n, done_n, last_n, valid_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] data_n;
    logic [ROW_W-1:0]  crow_n;
    logic [COL_W-1:0]  ccol_n;
    logic              at_last_col, at_last;
    logic [ROW_W-1:0]  adv_row;
    logic [COL_W-1:0]  adv_col;
`ifdef GRID_SCAN_ROWFULL_EN
    logic              acc, acc_n, acc_in, full_n;
`endif

    function automatic logic [ADDR_W-1:0] addr_of(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
        return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    assign at_last_col = (col == COL_W'(COLS - 2));
    assign at_last     = at_last_col && (row == ROW_W'(ROWS - 1));
    assign adv_col     = at_last_col ? COL_W'(1) : col + COL_W'(1);
    assign adv_row     = at_last_col ? row + ROW_W'(1) : row;
`ifdef GRID_SCAN_ROWFULL_EN
    // Re-arm at the first interior column, then AND in each captured cell.
    assign acc_in = ((col == COL_W'(1)) || acc) && (mem_q != '0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    // Next state and next values of every registered output
    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        busy_n  = busy;
        done_n  = 1'b0;
        addr_n  = mem_addr;
        data_n  = cell_data;
        crow_n  = cell_row;
        ccol_n  = cell_col;
        last_n  = cell_last;
        valid_n = 1'b0;
`ifdef GRID_SCAN_ROWFULL_EN
        acc_n   = acc;
        full_n  = row_full;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_ADDR;
                    row_n   = '0;
                    col_n   = COL_W'(1);
                    busy_n  = 1'b1;
                    addr_n  = addr_of('0, COL_W'(1));
                end
            end
            S_ADDR: state_n = S_CAPT;
            S_CAPT: begin
                state_n = S_OUT;
                data_n  = mem_q;
                crow_n  = row;
                ccol_n  = col;
                last_n  = at_last;
                valid_n = 1'b1;
`ifdef GRID_SCAN_ROWFULL_EN
                acc_n   = acc_in;
                full_n  = at_last_col && acc_in;
`endif
            end
            S_OUT: begin
                if (!cell_ready) begin
                    valid_n = 1'b1;
                end else if (at_last) begin
                    state_n = S_DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    state_n = S_ADDR;
                    row_n   = adv_row;
                    col_n   = adv_col;
                    addr_n  = addr_of(adv_row, adv_col);
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row        <= '0;
            col        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_addr   <= '0;
            cell_data  <= '0;
            cell_row   <= '0;
            cell_col   <= '0;
            cell_last  <= 1'b0;
            cell_valid <= 1'b0;
`ifdef GRID_SCAN_ROWFULL_EN
            acc        <= 1'b0;
            row_full   <= 1'b0;
`endif
        end else begin
            row        <= row_n;
            col        <= col_n;
            busy       <= busy_n;
            done       <= done_n;
            mem_addr   <= addr_n;
            cell_data  <= data_n;
            cell_row   <= crow_n;
            cell_col   <= ccol_n;
            cell_last  <= last_n;
            cell_valid <= valid_n;
`ifdef GRID_SCAN_ROWFULL_EN
            acc        <= acc_n;
            row_full   <= full_n;
`endif
        end
    end

endmodule

// File: tb/tb_grid_scan_reader.sv
// Self-checking bench for grid_scan_reader: vector table, directed corner sequences and random scans
// against a cell-list model built from the grid contents. Honours GRID_SCAN_ROWFULL_EN.
module tb_grid_scan_reader;

    localparam int COLS  = 12;
    localparam int ROWS  = 20;
    localparam int NCELL = (COLS - 2) * ROWS;
    localparam int LIMIT = 5000;

    logic       clk, rst, start, busy, done, cell_last, cell_valid, cell_ready;
    logic [7:0] mem_addr, mem_q, cell_data;
    logic [4:0] cell_row;
    logic [3:0] cell_col;
`ifdef GRID_SCAN_ROWFULL_EN
    logic       row_full;
`endif

    logic [7:0] grid [0:255];
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int data;
        int row;
        int col;
        int last;
        int addr;
        int full;
    } cell_t;

    typedef struct {
        int idx;
        int row;
        int col;
        int addr;
        int data;
        int last;
    } probe_t;

    cell_t  exp_q[$];
    probe_t probes[7];
    int log_row [NCELL];
    int log_col [NCELL];
    int log_data[NCELL];
    int log_last[NCELL];
    int log_addr[NCELL];
    int log_full[NCELL];

    grid_scan_reader #(.COLS(12), .ROWS(20), .ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_q      (mem_q),
        .cell_data  (cell_data),
        .cell_row   (cell_row),
        .cell_col   (cell_col),
        .cell_last  (cell_last),
        .cell_valid (cell_valid),
        .cell_ready (cell_ready)
`ifdef GRID_SCAN_ROWFULL_EN
        ,
        .row_full   (row_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read grid RAM
    always @(posedge clk) mem_q <= grid[mem_addr];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cur_full();
`ifdef GRID_SCAN_ROWFULL_EN
        return int'(row_full);
`else
        return 0;
`endif
    endfunction

    // Expected frame: every interior cell, top row first, left to right
    task automatic build_model();
        cell_t e;
        exp_q.delete();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 1; c <= COLS - 2; c++) begin
                e.data = int'(grid[r * COLS + c]);
                e.row  = r;
                e.col  = c;
                e.addr = r * COLS + c;
                e.last = (r == ROWS - 1 && c == COLS - 2) ? 1 : 0;
                e.full = (c == COLS - 2) ? 1 : 0;
                for (int k = 1; k <= COLS - 2; k++)
                    if (grid[r * COLS + k] == 8'd0) e.full = 0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  int'(busy), 0);
        check({tag, "_done"},  int'(done), 0);
        check({tag, "_addr"},  int'(mem_addr), 0);
        check({tag, "_data"},  int'(cell_data), 0);
        check({tag, "_row"},   int'(cell_row), 0);
        check({tag, "_col"},   int'(cell_col), 0);
        check({tag, "_last"},  int'(cell_last), 0);
        check({tag, "_valid"}, int'(cell_valid), 0);
        check({tag, "_full"},  cur_full(), 0);
    endtask

    // One scan: stall a chosen cell, re-pulse start mid-scan, or abort with reset
    task automatic run_scan(input int stall_at, input int stall_len, input int restart_at,
                            input int abort_at, input bit rand_ready, input bit timed);
        int    xfers, cyc, dones, stall_cnt;
        bit    fin, aborted, restarted;
        cell_t e;
        build_model();
        xfers = 0; cyc = 0; dones = 0; stall_cnt = 0;
        fin = 0; aborted = 0; restarted = 0;
        @(negedge clk);
        start      = 1'b1;
        cell_ready = 1'b1;
        while (!fin && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (abort_at >= 0 && xfers == abort_at && cell_valid) begin
                rst = 1'b0;
                #1;
                check_all_zero("abort");
                @(negedge clk);
                rst = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("abort_no_done", int'(done), 0);
                    check("abort_idle", int'(busy), 0);
                end
                fin = 1; aborted = 1;
            end else begin
                if (restart_at >= 0 && xfers == restart_at && cell_valid && !restarted) begin
                    start = 1'b1;
                    restarted = 1;
                end
                if (cell_valid && xfers == stall_at && stall_cnt < stall_len) begin
                    cell_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    cell_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                if (done) begin
                    dones++;
                    check("done_busy", int'(busy), 0);
                    check("done_valid", int'(cell_valid), 0);
                    if (timed) check("done_cycle", cyc, 3 * NCELL + 1);
                    fin = 1;
                end else if (cell_valid) begin
                    if (exp_q.size() == 0) begin
                        check("extra_cell", 1, 0);
                        fin = 1;
                    end else begin
                        e = exp_q[0];
                        check("cell_data", int'(cell_data), e.data);
                        check("cell_row",  int'(cell_row), e.row);
                        check("cell_col",  int'(cell_col), e.col);
                        check("cell_last", int'(cell_last), e.last);
                        check("mem_addr",  int'(mem_addr), e.addr);
                        check("no_wall", int'(mem_addr % COLS != 0 && mem_addr % COLS != COLS - 1), 1);
                        check("busy_out", int'(busy), 1);
`ifdef GRID_SCAN_ROWFULL_EN
                        check("row_full", int'(row_full), e.full);
`endif
                        if (cell_ready) begin
                            if (timed) check("xfer_cycle", cyc, 3 * (xfers + 1));
                            log_row[xfers]  = int'(cell_row);
                            log_col[xfers]  = int'(cell_col);
                            log_data[xfers] = int'(cell_data);
                            log_last[xfers] = int'(cell_last);
                            log_addr[xfers] = int'(mem_addr);
                            log_full[xfers] = cur_full();
                            void'(exp_q.pop_front());
                            xfers++;
                        end
                    end
                end else begin
                    check("busy_scan", int'(busy), 1);
                end
            end
        end
        start = 1'b0;
        if (!fin) check("scan_timeout", cyc, -1);
        if (!aborted) begin
            check("transfers", xfers, NCELL);
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (done) dones++;
                check("post_idle_busy", int'(busy), 0);
            end
            check("done_count", dones, 1);
        end
    endtask

    initial begin
        int nlast;
        probes[0] = '{0,   0,  1,  1,   0, 0};
        probes[1] = '{9,   0,  10, 10,  0, 0};
        probes[2] = '{10,  1,  1,  13,  0, 0};
        probes[3] = '{19,  1,  10, 22,  0, 0};
        probes[4] = '{115, 11, 6,  138, 0, 0};
        probes[5] = '{190, 19, 1,  229, 6, 0};
        probes[6] = '{199, 19, 10, 238, 6, 1};

        rst = 1'b0; start = 1'b0; cell_ready = 1'b0;
        for (int a = 0; a < 256; a++) grid[a] = 8'd0;
        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // Row 19 interior holds 6, rest empty
        for (int a = 229; a <= 238; a++) grid[a] = 8'd6;
        run_scan(-1, 0, -1, -1, 0, 1);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("probe%0d_row", i),  log_row[probes[i].idx],  probes[i].row);
            check($sformatf("probe%0d_col", i),  log_col[probes[i].idx],  probes[i].col);
            check($sformatf("probe%0d_addr", i), log_addr[probes[i].idx], probes[i].addr);
            check($sformatf("probe%0d_data", i), log_data[probes[i].idx], probes[i].data);
            check($sformatf("probe%0d_last", i), log_last[probes[i].idx], probes[i].last);
        end
        nlast = 0;
        for (int i = 0; i < NCELL; i++) nlast += log_last[i];
        check("last_count", nlast, 1);
        for (int i = 0; i < NCELL; i++)
            check("addr_seq", log_addr[i], (i / 10) * COLS + (i % 10) + 1);
`ifdef GRID_SCAN_ROWFULL_EN
        for (int i = 0; i < NCELL; i++)
            check("rowfull_t1", log_full[i], (i == NCELL - 1) ? 1 : 0);
`endif

        // Backpressure on cell (0,3)
        for (int a = 0; a < 256; a++) grid[a] = 8'd0;
        grid[3] = 8'd4;
        run_scan(2, 7, -1, -1, 0, 0);
        check("stall_data", log_data[2], 4);

        // Start while busy, then reset mid-scan, then a clean rescan
        for (int a = 0; a < 256; a++) grid[a] = 8'((a % 7) + 1);
        run_scan(-1, 0, 50, -1, 0, 1);
        run_scan(-1, 0, -1, 120, 0, 0);
        run_scan(-1, 0, -1, -1, 0, 1);
        check("restart_first_row", log_row[0], 0);
        check("restart_first_col", log_col[0], 1);

        // Row 18 full except its last interior cell, then fill that cell
        for (int a = 0; a < 256; a++) grid[a] = 8'd0;
        for (int a = 217; a <= 225; a++) grid[a] = 8'd1;
        run_scan(-1, 0, -1, -1, 1, 0);
`ifdef GRID_SCAN_ROWFULL_EN
        check("rowfull_r18_gap", log_full[189], 0);
`endif
        grid[226] = 8'd3;
        run_scan(-1, 0, -1, -1, 1, 0);
`ifdef GRID_SCAN_ROWFULL_EN
        check("rowfull_r18_full", log_full[189], 1);
`endif

        // Random grids with some full rows and random backpressure
        for (int n = 0; n < 3; n++) begin
            for (int a = 0; a < 256; a++) grid[a] = 8'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) begin
                int r;
                r = int'($urandom_range(0, ROWS - 1));
                for (int c = 1; c <= COLS - 2; c++) grid[r * COLS + c] = 8'($urandom_range(1, 255));
            end
            run_scan(-1, 0, -1, -1, 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
